// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and default register-file dimensions.
package cpu_types_pkg;

  localparam int unsigned DEFAULT_NUM_REGS = 32;
  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_IDX_W    = $clog2(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_DATA_W-1:0] word_t;
  typedef logic [DEFAULT_IDX_W-1:0]  reg_w;

endpackage

// File: rtl/register_file_if.sv
// Bundle of register-file signals with register-file and driver views.
interface register_file_if
  import cpu_types_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input logic clk
);

  logic                           rst;
  logic [NUM_RD-1:0][IDX_W-1:0]   read_index;
  logic [NUM_RD-1:0][DATA_W-1:0]  read_data;
  logic [NUM_RD-1:0]              read_busy;
  logic [NUM_WR-1:0]              reg_write;
  logic [NUM_WR-1:0][IDX_W-1:0]   write_index;
  logic [NUM_WR-1:0][DATA_W-1:0]  write_data;
  logic                           reserve;
  logic [IDX_W-1:0]               reserve_index;
  logic                           reserve_ack;

  modport rf (
    input  clk, rst, read_index, reg_write, write_index, write_data,
           reserve, reserve_index,
    output read_data, read_busy, reserve_ack
  );

  modport tb (
    input  clk, read_data, read_busy, reserve_ack,
    output rst, read_index, reg_write, write_index, write_data,
           reserve, reserve_index
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write bits: reserve sets, writes clear, set wins.
module reg_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned NUM_WR   = 1,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         reserve,
  input  logic [IDX_W-1:0]             reserve_index,
  input  logic [NUM_WR-1:0]            reg_write,
  input  logic [NUM_WR-1:0][IDX_W-1:0] write_index,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         reserve_ack_c
);

  // Accept a reservation only for a free, nonzero register outside reset
  always_comb begin
    reserve_ack_c = 1'b0;
    if (!rst && reserve && (reserve_index != '0) && !busy[reserve_index]) begin
      reserve_ack_c = 1'b1;
    end
  end

  // Busy bits: clears from writes first, then an accepted reserve overrides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (reg_write[w] && (write_index[w] != '0)) begin
          busy[write_index[w]] <= 1'b0;
        end
      end
      if (reserve_ack_c) begin
        busy[reserve_index] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with optional write forwarding and scoreboard.
module register_file_mp
  import cpu_types_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD-1:0][IDX_W-1:0]  read_index,
  output logic [NUM_RD-1:0][DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]             read_busy,
  input  logic [NUM_WR-1:0]             reg_write,
  input  logic [NUM_WR-1:0][IDX_W-1:0]  write_index,
  input  logic [NUM_WR-1:0][DATA_W-1:0] write_data,
  input  logic                          reserve,
  input  logic [IDX_W-1:0]              reserve_index,
  output logic                          reserve_ack
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .reserve       (reserve),
    .reserve_index (reserve_index),
    .reg_write     (reg_write),
    .write_index   (write_index),
    .busy          (busy),
    .reserve_ack_c (reserve_ack)
  );

  // Register array; later ports overwrite earlier ones on the same index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (reg_write[w] && (write_index[w] != '0)) begin
          regs[write_index[w]] <= write_data[w];
        end
      end
    end
  end

  // Zero-latency reads with optional forwarding of this cycle's writes
  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      if (!rst && (read_index[r] != '0)) begin
        read_data[r] = regs[read_index[r]];
        read_busy[r] = busy[read_index[r]];
        if (BYPASS != 0) begin
          for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (reg_write[w] && (write_index[w] == read_index[r])) begin
              read_data[r] = write_data[w];
              read_busy[r] = 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: forwarding and non-forwarding copies share one stimulus.
module tb_register_file_mp;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  register_file_if #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(2), .NUM_WR(2)) bus (.clk(clk));

  logic [1:0][31:0] read_data_nb;
  logic [1:0]       read_busy_nb;
  logic             reserve_ack_nb;

  register_file_mp #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
    .clk(clk), .rst(bus.rst), .read_index(bus.read_index), .read_data(bus.read_data),
    .read_busy(bus.read_busy), .reg_write(bus.reg_write), .write_index(bus.write_index),
    .write_data(bus.write_data), .reserve(bus.reserve), .reserve_index(bus.reserve_index),
    .reserve_ack(bus.reserve_ack)
  );

  register_file_mp #(.NUM_REGS(32), .DATA_W(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(bus.rst), .read_index(bus.read_index), .read_data(read_data_nb),
    .read_busy(read_busy_nb), .reg_write(bus.reg_write), .write_index(bus.write_index),
    .write_data(bus.write_data), .reserve(bus.reserve), .reserve_index(bus.reserve_index),
    .reserve_ack(reserve_ack_nb)
  );

  // Reference state: architectural contents and pending flags
  word_t m_regs [32];
  bit    m_busy [32];
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Forwarded value: last active write port naming the index wins
  function automatic word_t exp_read(input reg_w idx, input bit fwd);
    word_t v;
    if (bus.rst || idx == 0) return '0;
    v = m_regs[idx];
    if (fwd)
      for (int w = 0; w < 2; w++)
        if (bus.reg_write[w] && bus.write_index[w] == idx) v = bus.write_data[w];
    return v;
  endfunction

  function automatic bit exp_busy(input reg_w idx, input bit fwd);
    if (bus.rst || idx == 0) return 1'b0;
    if (fwd)
      for (int w = 0; w < 2; w++)
        if (bus.reg_write[w] && bus.write_index[w] == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  function automatic bit exp_ack();
    return !bus.rst && bus.reserve && bus.reserve_index != 0 && !m_busy[bus.reserve_index];
  endfunction

  task automatic check_outputs(input string tag);
    for (int r = 0; r < 2; r++) begin
      check($sformatf("%s_rd_fwd%0d", tag, r), bus.read_data[r], exp_read(bus.read_index[r], 1'b1));
      check($sformatf("%s_rd_nofwd%0d", tag, r), read_data_nb[r], exp_read(bus.read_index[r], 1'b0));
      check($sformatf("%s_busy_fwd%0d", tag, r), 32'(bus.read_busy[r]), 32'(exp_busy(bus.read_index[r], 1'b1)));
      check($sformatf("%s_busy_nofwd%0d", tag, r), 32'(read_busy_nb[r]), 32'(exp_busy(bus.read_index[r], 1'b0)));
    end
    check({tag, "_ack_fwd"}, 32'(bus.reserve_ack), 32'(exp_ack()));
    check({tag, "_ack_nofwd"}, 32'(reserve_ack_nb), 32'(exp_ack()));
  endtask

  // Advance the reference by one clock edge using the presented inputs
  task automatic model_edge();
    bit ack;
    if (bus.rst) begin
      model_reset();
      return;
    end
    ack = exp_ack();
    for (int w = 0; w < 2; w++)
      if (bus.reg_write[w] && bus.write_index[w] != 0) begin
        m_regs[bus.write_index[w]] = bus.write_data[w];
        m_busy[bus.write_index[w]] = 1'b0;
      end
    if (ack) m_busy[bus.reserve_index] = 1'b1;
  endtask

  task automatic idle();
    bus.reg_write     = '0;
    bus.write_index   = '0;
    bus.write_data    = '0;
    bus.reserve       = 1'b0;
    bus.reserve_index = '0;
  endtask

  task automatic rd(input int a, input int b);
    bus.read_index[0] = 5'(a);
    bus.read_index[1] = 5'(b);
  endtask

  task automatic wr(input int port, input int idx, input logic [31:0] data);
    bus.reg_write[port]   = 1'b1;
    bus.write_index[port] = 5'(idx);
    bus.write_data[port]  = data;
  endtask

  task automatic rsv(input int idx);
    bus.reserve       = 1'b1;
    bus.reserve_index = 5'(idx);
  endtask

  // One cycle: inputs already set just after an edge; check mid-cycle
  task automatic step(input string tag);
    #4;
    check_outputs(tag);
    model_edge();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    model_reset();
    idle();
    rd(0, 0);
    bus.rst = 1'b1;
    #1;
    // Reset sweep, with writes presented that must be ignored
    for (int i = 0; i < 16; i++) begin
      rd(2 * i, 2 * i + 1);
      wr(0, 2 * i, $urandom);
      wr(1, 2 * i + 1, $urandom);
      rsv(2 * i + 1);
      #2;
      check_outputs("reset");
    end
    @(posedge clk);
    #1;
    idle();
    bus.rst = 1'b0;

    // Write then read, and x0 stays zero
    wr(0, 5, 32'hDEADBEEF); rd(5, 0);  step("wr_r5");
    rd(5, 0);                           step("rd_r5");
    wr(0, 0, 32'h1234); rd(0, 5);       step("wr_r0");
    rd(0, 5);                           step("rd_r0");
    // Same-cycle forwarding versus old contents
    wr(1, 7, 32'hA5A5A5A5); rd(7, 7);   step("fwd_r7");
    rd(7, 5);                           step("rd_r7");
    // Port conflict: highest port wins
    wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(3, 3); step("conf_r3");
    rd(3, 0);                           step("rd_r3");
    // Scoreboard sequence
    rsv(9); rd(9, 0);                   step("rsv_r9");
    rsv(9); rd(9, 9);                   step("rsv_again");
    rsv(0); rd(0, 9);                   step("rsv_r0");
    wr(0, 9, 32'h99); rd(9, 9);         step("wr_r9");
    rd(9, 0);                           step("free_r9");
    rsv(9); wr(1, 9, 32'h98); rd(9, 9); step("rsv_wr_free");
    rd(9, 0);                           step("busy_r9");
    rsv(9); wr(0, 9, 32'h97); rd(9, 9); step("rsv_wr_busy");
    rd(9, 0);                           step("clear_r9");
    rsv(9); rd(9, 5);                   step("rsv_r9b");

    // Asynchronous reset between edges while r9 busy and r5 loaded
    rd(5, 9); wr(0, 5, 32'h77); rsv(3);
    #2;
    bus.rst = 1'b1;
    model_reset();
    #1;
    check_outputs("mid_rst");
    @(posedge clk);
    #4;
    check_outputs("mid_rst_hold");
    bus.rst = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rd(5, 3);                           step("post_rst");
    rd(9, 3);                           step("post_rst2");

    // Randomized traffic focused on a few registers to force collisions
    for (int n = 0; n < 300; n++) begin
      rd($urandom_range(0, 11), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 11));
      for (int w = 0; w < 2; w++)
        if ($urandom_range(0, 2) == 0) wr(w, $urandom_range(0, 11), $urandom);
      if ($urandom_range(0, 1) == 0) rsv($urandom_range(0, 11));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the architectural register count (power of two, at least 2); IDX_W = log2(NUM_REGS).
REQ-003 Parameter DATA_W, default 32, SHALL set the register width.
REQ-004 Parameter NUM_RD, default 2, SHALL set the read-port count (1..4).
REQ-005 Parameter NUM_WR, default 1, SHALL set the write-port count (1..2).
REQ-006 Parameter BYPASS, default 1, SHALL select whether same-cycle writes are forwarded to read data (1 = forward, 0 = no forwarding).
REQ-007 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- read_index  in  NUM_RD x IDX_W  per-port read address
- read_data  out  NUM_RD x DATA_W  per-port read value
- read_busy  out  NUM_RD  per-port flag: the indexed register has a pending write
- reg_write  in  NUM_WR  per-port write enable
- write_index  in  NUM_WR x IDX_W  per-port write address
- write_data  in  NUM_WR x DATA_W  per-port write value
- reserve  in  1  mark a destination register as pending
- reserve_index  in  IDX_W  register to reserve
- reserve_ack  out  1  the reservation was accepted this cycle

Function
REQ-008 Register 0 SHALL always read as 0; writes and reservations to index 0 SHALL be ignored, and read_busy for index 0 SHALL always be 0.
REQ-009 Reads SHALL be combinational: read_data SHALL reflect the array contents in the same cycle, with zero latency.
REQ-010 A write with reg_write=1 SHALL update the array at the next rising clock edge.
REQ-011 When BYPASS=1 and a read index equals an active write index (nonzero), read_data SHALL return the write_data of that cycle.
REQ-012 When BYPASS=0, a read in the same situation SHALL return the old array contents.
REQ-013 When two write ports target the same nonzero index in one cycle, the highest-numbered port SHALL win, for both the stored value and the bypassed value.
REQ-014 The scoreboard SHALL hold one busy bit per register.
REQ-015 A reserve with a nonzero index whose busy bit is clear SHALL set that busy bit at the next edge, and reserve_ack SHALL be 1 combinationally in that cycle.
REQ-016 A reserve to a register that is already busy, or to index 0, SHALL be rejected: reserve_ack=0 and no state change.
REQ-017 Any accepted write SHALL clear the busy bit of its index at the next edge.
REQ-018 If a reserve and a write hit the same index in the same cycle, the reserve SHALL be evaluated against the pre-edge busy value, and set SHALL take priority over clear: if the bit was clear, the result is busy=1; if it was busy, the reserve is rejected and the bit ends clear.
REQ-019 read_busy SHALL reflect the registered busy bit; when BYPASS=1, a same-cycle write to that index SHALL force read_busy=0.
REQ-020 Indices at or above NUM_REGS are unreachable by construction, because IDX_W is exact.

Reset
REQ-021 While rst=1, all registers SHALL asynchronously become 0 and all busy bits SHALL become 0.
REQ-022 While rst=1, read_data SHALL be 0 for every port, read_busy SHALL be 0 and reserve_ack SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL discard any write or reserve presented in the same cycle.
REQ-024 Normal operation SHALL resume at the first rising edge after rst deasserts.

Structure
REQ-025 The types word_t (DATA_W wide) and reg_w (IDX_W wide), and the default NUM_REGS and DATA_W constants, SHALL live in cpu_types_pkg.
REQ-026 The busy-bit logic SHALL be a single sub-module, reg_scoreboard, parametrised by NUM_REGS and NUM_WR.
REQ-027 register_file_if SHALL be extended with array-typed port members and with rf and tb modports whose directions match REQ-007.

Verification
REQ-028 Reset check: assert rst, then read indices 0..31 -> all read_data=0 and all read_busy=0.
REQ-029 Write/read and x0 check: write 0xDEADBEEF to r5, then read r5 on the next cycle -> 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0.
REQ-030 Bypass check: with BYPASS=1, write 0xA5A5A5A5 to r7 while reading r7 in the same cycle -> 0xA5A5A5A5. With BYPASS=0, the same stimulus -> the old value.
REQ-031 Write-port conflict: with NUM_WR=2, port0 writes r3=0x11 and port1 writes r3=0x22 in the same cycle -> r3 reads 0x22 on the next cycle.
REQ-032 Scoreboard sequence: reserve r9 -> ack=1 and read_busy=1 on the next cycle; reserve r9 again -> ack=0; write r9 -> busy clears on the next cycle; a simultaneous reserve and write to r9 while r9 is free -> busy=1.
REQ-033 Reset mid-operation: assert rst asynchronously, between clock edges, while r9 is busy and r5=0xDEADBEEF -> immediately read_busy=0 and r5 reads 0.
